seq_restoring_divider: RTL

- Sequential restoring divider: the inverse of the team's 4x4 array multiplier.
- Takes an NW-bit dividend (the multiplier's product width) and a DW-bit divisor. Produces an NW-bit quotient and a DW-bit remainder.
- Computes one quotient bit per clock behind a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic tile. The tile wrapper drives it from the dedicated inputs and registered IO inputs.

---
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential restoring divider.
// master drives the request side; slave is the divider itself.
interface seq_restoring_divider_if #(
    parameter int NW = 8,
    parameter int DW = 4
);
    logic          start;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, NW iterations per divide.
// Results are registered on entry to DONE and held until the next completion.
module seq_restoring_divider #(
    parameter int NW = 8,
    parameter int DW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DZ, DONE} state_t;

    state_t        state_q, state_d;
    logic          accept;
    logic [DW:0]   p_q;
    logic [NW-1:0] q_q;
    logic [DW-1:0] d_q;
    logic [CW-1:0] cnt_q;
    logic [NW-1:0] quotient_q;
    logic [DW-1:0] remainder_q;
    logic          dz_q;

    // One restoring iteration. P's top bit is always zero, so widening the
    // shifted value by that bit leaves the compare unchanged.
    logic [DW+1:0] t_w;
    logic          ge;
    logic [DW:0]   p_next;
    logic [NW-1:0] q_next;

    always_comb begin
        t_w    = {p_q, q_q[NW-1]};
        ge     = (t_w >= {2'b00, d_q});
        p_next = ge ? (DW+1)'(t_w - {2'b00, d_q}) : t_w[DW:0];
        q_next = {q_q[NW-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (bus.divisor == '0) ? DZ : RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN:     if (cnt_q == CW'(1)) state_d = DONE;
            DZ:      if (cnt_q == '0)     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else if (accept) begin
            d_q   <= bus.divisor;
            q_q   <= bus.dividend;
            p_q   <= '0;
            // DZ reuses the counter to dwell two cycles, matching the zero-divisor latency.
            cnt_q <= (bus.divisor == '0) ? CW'(1) : CW'(NW);
        end else begin
            case (state_q)
                RUN: begin
                    p_q   <= p_next;
                    q_q   <= q_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quotient_q  <= q_next;
                        remainder_q <= p_next[DW-1:0];
                        dz_q        <= 1'b0;
                    end
                end
                DZ: begin
                    if (cnt_q == '0) begin
                        quotient_q  <= '1;
                        remainder_q <= '0;
                        dz_q        <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dz_q;
endmodule
